// File: rtl/pipo_seq_ctrl.sv
// pipo_seq_ctrl: Moore FSM that sequences an iterative datapath built from
// PIPO registers. One operation is LOAD (operand enable pulse), ITER cycles
// of RUN (iteration enable), STORE (result enable pulse), and DONE (completion pulse).
module pipo_seq_ctrl #(
  parameter int unsigned ITER = 8,
  parameter int unsigned CW   = ($clog2(ITER) > 0) ? $clog2(ITER) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          ld_op,
  output logic          iter_en,
  output logic          ld_res,
  output logic [CW-1:0] iter_cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StStore = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [CW-1:0] LastCnt = CW'(ITER - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update; abort outranks every transition out of a busy state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          // abort in IDLE suppresses a simultaneous start
          if (start && !abort) state_d = StLoad;
        end
        StLoad: begin
          cnt_d   = '0;
          state_d = StRun;
        end
        StRun: begin
          // Exit compare keeps the counter from ever passing ITER-1.
          if (cnt_q == LastCnt) begin
            state_d = StStore;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StStore: state_d = StDone;
        StDone: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        default: begin
          // Unreachable encodings recover to IDLE.
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    ld_op   = 1'b0;
    iter_en = 1'b0;
    ld_res  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StLoad: begin
        ld_op = 1'b1;
        busy  = 1'b1;
      end
      StRun: begin
        iter_en = 1'b1;
        busy    = 1'b1;
      end
      StStore: begin
        ld_res = 1'b1;
        busy   = 1'b1;
      end
      StDone: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_pipo_seq_ctrl.sv
// Testbench for pipo_seq_ctrl: ITER=8 and ITER=1 instances share stimulus and
// are checked each cycle against an operation-age timeline model.
module tb_pipo_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic       ld_op8, iter_en8, ld_res8, busy8, done8;
  logic [2:0] iter_cnt8;
  logic       ld_op1, iter_en1, ld_res1, busy1, done1;
  logic [0:0] iter_cnt1;

  always #5 clk = ~clk;

  pipo_seq_ctrl #(.ITER(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ld_op(ld_op8), .iter_en(iter_en8), .ld_res(ld_res8),
    .iter_cnt(iter_cnt8), .busy(busy8), .done(done8)
  );

  pipo_seq_ctrl #(.ITER(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ld_op(ld_op1), .iter_en(iter_en1), .ld_res(ld_res1),
    .iter_cnt(iter_cnt1), .busy(busy1), .done(done1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: age = cycles since the accepted start edge (0 = idle).
  // Cycle 1 loads, 2..ITER+1 iterate, ITER+2 stores, ITER+3 completes.
  function automatic int next_age(input int age, input int iter, input logic s, input logic a);
    if (age == 0) return (s && !a) ? 1 : 0;
    if (a) return 0;
    if (age == iter + 3) return 0;
    return age + 1;
  endfunction

  function automatic int exp_cnt(input int age, input int iter);
    if (age >= 2 && age <= iter + 1) return age - 2;
    if (age >= iter + 2) return iter - 1;
    return 0;
  endfunction

  int age8 = 0;
  int age1 = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age8 <= 0;
      age1 <= 0;
    end else begin
      age8 <= next_age(age8, 8, start, abort);
      age1 <= next_age(age1, 1, start, abort);
    end
  end

  // Event tallies used by the literal checks.
  int cyc = 0;
  int n_ldop8, n_ldres8, n_done8, n_busy8, n_iter8, t_ldop8, t_ldres8, t_done8, gap8;
  int n_ldop1, n_busy1, n_iter1, t_ldop1, t_ldres1, gap1;

  task automatic clear_counts();
    n_ldop8 = 0; n_ldres8 = 0; n_done8 = 0; n_busy8 = 0; n_iter8 = 0;
    t_ldop8 = 0; t_ldres8 = 0; t_done8 = 0; gap8 = 0;
    n_ldop1 = 0; n_busy1 = 0; n_iter1 = 0; t_ldop1 = 0; t_ldres1 = 0; gap1 = 0;
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    check("ld_op8",   ld_op8,    int'(age8 == 1));
    check("iter_en8", iter_en8,  int'(age8 >= 2 && age8 <= 9));
    check("ld_res8",  ld_res8,   int'(age8 == 10));
    check("done8",    done8,     int'(age8 == 11));
    check("busy8",    busy8,     int'(age8 != 0));
    check("cnt8",     iter_cnt8, exp_cnt(age8, 8));
    check("ld_op1",   ld_op1,    int'(age1 == 1));
    check("iter_en1", iter_en1,  int'(age1 == 2));
    check("ld_res1",  ld_res1,   int'(age1 == 3));
    check("done1",    done1,     int'(age1 == 4));
    check("busy1",    busy1,     int'(age1 != 0));
    check("cnt1",     iter_cnt1, exp_cnt(age1, 1));
    if (ld_op8) begin
      if (n_ldop8 > 0) gap8 = cyc - t_ldop8;
      n_ldop8++;
      t_ldop8 = cyc;
    end
    if (ld_res8) begin n_ldres8++; t_ldres8 = cyc; end
    if (done8) begin n_done8++; t_done8 = cyc; end
    if (busy8) n_busy8++;
    if (iter_en8) n_iter8++;
    if (ld_op1) begin
      if (n_ldop1 > 0) gap1 = cyc - t_ldop1;
      n_ldop1++;
      t_ldop1 = cyc;
    end
    if (ld_res1) t_ldres1 = cyc;
    if (busy1) n_busy1++;
    if (iter_en1) n_iter1++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  bit found;

  initial begin
    clear_counts();
    // Reset held, then released with start low.
    repeat (3) step();
    rst = 1'b1;
    repeat (3) step();
    check("rst_busy8", busy8, 0);
    check("rst_cnt8", iter_cnt8, 0);

    // Nominal single operation on both instances.
    clear_counts();
    pulse_start();
    repeat (14) step();
    check("nom_ldop8_n", n_ldop8, 1);
    check("nom_ldres8_n", n_ldres8, 1);
    check("nom_done8_n", n_done8, 1);
    check("nom_busy8_n", n_busy8, 11);
    check("nom_iter8_n", n_iter8, 8);
    check("nom_ldres8_t", t_ldres8 - t_ldop8, 9);
    check("nom_done8_t", t_done8 - t_ldop8, 10);
    check("it1_busy_n", n_busy1, 4);
    check("it1_iter_n", n_iter1, 1);
    check("it1_ldres_t", t_ldres1 - t_ldop1, 2);

    // start held for 24 edges: new op only from IDLE, never queued.
    clear_counts();
    start = 1'b1;
    repeat (24) step();
    start = 1'b0;
    repeat (14) step();
    check("b2b_ldop8_n", n_ldop8, 2);
    check("b2b_gap8", gap8, 12);
    check("b2b_done8_n", n_done8, 2);
    check("b2b_ldop1_n", n_ldop1, 5);
    check("b2b_gap1", gap1, 5);

    // Abort at iter_cnt=3.
    clear_counts();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (iter_en8 && iter_cnt8 == 3'd3) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("abort_reach", int'(found), 1);
    if (found) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy8", busy8, 0);
      check("abort_cnt8", iter_cnt8, 0);
    end
    repeat (12) step();
    check("abort_ldres8_n", n_ldres8, 0);
    check("abort_done8_n", n_done8, 0);

    // abort in IDLE overrides start.
    clear_counts();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    step();
    check("idle_abort_ldop8", n_ldop8, 0);
    check("idle_abort_busy8", busy8, 0);

    // Full sequence after an abort.
    clear_counts();
    pulse_start();
    repeat (14) step();
    check("post_abort_busy8", n_busy8, 11);
    check("post_abort_ldres8", n_ldres8, 1);
    check("post_abort_done8", n_done8, 1);

    // Asynchronous reset between edges at iter_cnt=5.
    clear_counts();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (iter_en8 && iter_cnt8 == 3'd5) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("arst_reach", int'(found), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_iter_en8", iter_en8, 0);
    check("arst_cnt8", iter_cnt8, 0);
    check("arst_busy8", busy8, 0);
    check("arst_ldres8", ld_res8, 0);
    check("arst_done8", done8, 0);
    step();
    step();
    rst = 1'b1;
    step();
    check("arst_ldres8_n", n_ldres8, 0);
    check("arst_done8_n", n_done8, 0);

    clear_counts();
    pulse_start();
    repeat (14) step();
    check("post_rst_busy8", n_busy8, 11);
    check("post_rst_iter8", n_iter8, 8);
    check("post_rst_done8_t", t_done8 - t_ldop8, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
